// File: rtl/coin_bcd_totalizer_if.sv
// rtl/coin_bcd_totalizer_if.sv - coin sensor, total and display signal bundle for the totalizer
interface coin_bcd_totalizer_if #(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_COINS  = 5
);
    logic [NUM_COINS-1:0]    coin;
    logic                    clr;
    logic [4*NUM_DIGITS-1:0] total_bcd;
    logic                    busy;
    logic                    credit_pulse;
    logic                    reject_pulse;
    logic                    overflow;
    logic [NUM_COINS-1:0]    LED;
    logic [6:0]              display;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output coin, clr,
        input  total_bcd, busy, credit_pulse, reject_pulse, overflow, LED, display, an
    );

    modport slave (
        input  coin, clr,
        output total_bcd, busy, credit_pulse, reject_pulse, overflow, LED, display, an
    );
endinterface

// File: rtl/coin_bcd_totalizer.sv
// rtl/coin_bcd_totalizer.sv - coin classifier, digit-serial BCD totalizer and multiplexed 7-segment scan
// Optional build macro COIN_TOTALIZER_LEADING_ZERO_BLANK_EN blanks leading zero digits on the display.
module coin_bcd_totalizer #(
    parameter int                      NUM_DIGITS    = 8,
    parameter int                      NUM_COINS     = 5,
    parameter logic [16*NUM_COINS-1:0] COIN_VALUES   = {16'h0100, 16'h0050, 16'h0020, 16'h0010, 16'h0005},
    parameter int                      SETTLE_CYCLES = 25_000_000,
    parameter int                      SCAN_DIV_BITS = 16
) (
    input logic                 CLK_50,
    input logic                 rst,
    coin_bcd_totalizer_if.slave bus
);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DW-1:0] LAST_DIGIT  = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ADD     = 2'd2;

    logic [NUM_COINS-1:0]    coin_meta;
    logic [NUM_COINS-1:0]    coin_sync;
    logic [NUM_COINS-1:0]    coin_prev;
    logic [NUM_COINS-1:0]    comb;
    logic [1:0]              state;
    logic [CW-1:0]           settle_cnt;
    logic [DW-1:0]           add_idx;
    logic                    carry;
    logic [15:0]             coin_val_q;
    logic [4*NUM_DIGITS-1:0] total_q;
    logic                    overflow_q;
    logic                    credit_q;
    logic                    reject_q;

    logic                    coin_rise;
    logic                    coin_hit;
    logic [15:0]             coin_val;
    logic [3:0]              cur_digit;
    logic [3:0]              val_digit;
    logic [4:0]              digit_sum;
    logic                    carry_out;
    logic [3:0]              wr_digit;

    // Only an all-zero to nonzero step of the synced bus starts a window.
    assign coin_rise = (coin_prev == '0) && (coin_sync != '0);

    // A window is valid only if it accumulated exactly lines [k:0].
    always_comb begin
        coin_hit = 1'b0;
        coin_val = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (comb == NUM_COINS'((64'd1 << (k + 1)) - 64'd1)) begin
                coin_hit = 1'b1;
                coin_val = COIN_VALUES[16*k +: 16];
            end
        end
    end

    always_comb begin
        cur_digit = total_q[4*add_idx +: 4];
        val_digit = '0;
        for (int d = 0; d < 4; d++) begin
            if (d < NUM_DIGITS && add_idx == DW'(d)) begin
                val_digit = coin_val_q[4*d +: 4];
            end
        end
        digit_sum = {1'b0, cur_digit} + {1'b0, val_digit} + {4'b0, carry};
        carry_out = digit_sum > 5'd9;
        wr_digit  = carry_out ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
    end

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            coin_meta  <= '0;
            coin_sync  <= '0;
            coin_prev  <= '0;
            comb       <= '0;
            state      <= S_IDLE;
            settle_cnt <= '0;
            add_idx    <= '0;
            carry      <= 1'b0;
            coin_val_q <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            coin_meta <= bus.coin;
            coin_sync <= coin_meta;
            coin_prev <= coin_sync;
            credit_q  <= 1'b0;
            reject_q  <= 1'b0;
            if (bus.clr) begin
                total_q    <= '0;
                overflow_q <= 1'b0;
                state      <= S_IDLE;
                settle_cnt <= '0;
                add_idx    <= '0;
                carry      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (coin_rise) begin
                            state      <= S_COLLECT;
                            comb       <= coin_sync;
                            settle_cnt <= CW'(1);
                        end
                    end
                    S_COLLECT: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            if (coin_hit) begin
                                state      <= S_ADD;
                                coin_val_q <= coin_val;
                                add_idx    <= '0;
                                carry      <= 1'b0;
                            end else begin
                                state    <= S_IDLE;
                                reject_q <= 1'b1;
                            end
                        end else begin
                            comb       <= comb | coin_sync;
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_ADD: begin
                        total_q[4*add_idx +: 4] <= wr_digit;
                        carry                   <= carry_out;
                        if (add_idx == LAST_DIGIT) begin
                            state    <= S_IDLE;
                            credit_q <= 1'b1;
                            // Carry out of the top digit saturates rather than wrapping.
                            if (carry_out) begin
                                total_q    <= {NUM_DIGITS{4'h9}};
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            add_idx <= add_idx + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.total_bcd    = total_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.credit_pulse = credit_q;
    assign bus.reject_pulse = reject_q;
    assign bus.overflow     = overflow_q;
    assign bus.LED          = coin_sync;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [SCAN_DIV_BITS-1:0] presc;
    logic [DW-1:0]            scan_idx;
    logic [DW-1:0]            scan_nxt;
    logic [3:0]               scan_digit;
    logic                     blank;
    logic [6:0]               display_q;
    logic [NUM_DIGITS-1:0]    an_q;

    always_comb begin
        scan_nxt = scan_idx;
        if (&presc) begin
            scan_nxt = (scan_idx == LAST_DIGIT) ? '0 : scan_idx + 1'b1;
        end
        scan_digit = total_q[4*scan_nxt +: 4];
    end

`ifdef COIN_TOTALIZER_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (total_q[4*i +: 4] == 4'd0);
            lead_zero[i] = zero_run;
        end
    end

    // Digit 0 is never blanked so an empty total still reads '0'.
    assign blank = lead_zero[scan_nxt] && (scan_nxt != '0);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge CLK_50) begin
        if (rst) begin
            presc     <= '0;
            scan_idx  <= '0;
            an_q      <= ~NUM_DIGITS'(1);
            display_q <= 7'b1000000;
        end else begin
            presc     <= presc + 1'b1;
            scan_idx  <= scan_nxt;
            an_q      <= ~(NUM_DIGITS'(1) << scan_nxt);
            display_q <= blank ? 7'b1111111 : seg7(scan_digit);
        end
    end

    assign bus.display = display_q;
    assign bus.an      = an_q;
endmodule
